// File: rtl/pi_seq_pkg.sv
// pi_seq_pkg: shared types and default widths for the PI control sequencer.
// No ports; provides state/direction enums and code-width localparams.
package pi_seq_pkg;
    localparam int NBIT  = 9;
    localparam int NSTEP = 4;
    localparam int NHOLD = 4;
    localparam int CW    = NBIT + 1;
    typedef enum logic [1:0] {IDLE, CALC, STEP, HOLD} state_t;
    typedef enum logic {UP, DN} dir_t;
endpackage

// File: rtl/pi_mod_dist.sv
// pi_mod_dist: shortest modular path from cur to tgt on a ring of p codes.
// Ports: cur, tgt (both < p), p (ring size) in; dir (UP/DN) and rem (distance) out.
module pi_mod_dist
    import pi_seq_pkg::*;
#(
    parameter int W = CW
) (
    input  logic [W-1:0] cur,
    input  logic [W-1:0] tgt,
    input  logic [W-1:0] p,
    output dir_t         dir,
    output logic [W-1:0] rem
);
    logic [W-1:0] d;
    // tgt + p stays below 2^W because both operands are at most 2^(W-1)
    assign d   = (tgt >= cur) ? tgt - cur : tgt + p - cur;
    // exactly half way round resolves upward
    assign dir = (d <= (p >> 1)) ? UP : DN;
    assign rem = (dir == UP) ? d : p - d;
endmodule

// File: rtl/pi_ctl_sequencer.sv
// pi_ctl_sequencer: walks the PI code toward an accepted target along the shortest modular path.
// Ports: clk, rstb (async low); en; period/max_step/holdoff config; tgt_valid/tgt_code/tgt_ready
// target handshake; ctl/ctl_valid PI update; busy; wrap_up/wrap_dn slip pulses; err_range sticky.
module pi_ctl_sequencer
    import pi_seq_pkg::*;
#(
    parameter int Nbit  = NBIT,
    parameter int Nstep = NSTEP,
    parameter int Nhold = NHOLD
) (
    input  logic             clk,
    input  logic             rstb,
    input  logic             en,
    input  logic [Nbit:0]    period,
    input  logic [Nstep-1:0] max_step,
    input  logic [Nhold-1:0] holdoff,
    input  logic             tgt_valid,
    input  logic [Nbit-1:0]  tgt_code,
    output logic             tgt_ready,
    output logic [Nbit-1:0]  ctl,
    output logic             ctl_valid,
    output logic             busy,
    output logic             wrap_up,
    output logic             wrap_dn,
    output logic             err_range
);
    localparam int W = Nbit + 1;
    state_t           state, state_n;
    dir_t             dir, dir_n, dist_dir;
    logic [W-1:0]     ctl_r, ctl_n, p_lat, p_n, t, t_n, rem, rem_n, dist_rem;
    logic [W-1:0]     s1, st, up_sum, n, tgt_w;
    logic [Nhold-1:0] hcnt, hcnt_n;
    logic             err_n, vld_n, up_n, dn_n, wu, wd, tgt_oor;

    // ctl is held one bit wider so every comparison sees the full arithmetic width
    assign ctl       = ctl_r[Nbit-1:0];
    assign busy      = state != IDLE;
    assign tgt_ready = en && state == IDLE;
    assign tgt_w     = W'(tgt_code);
    assign tgt_oor   = tgt_w >= period;
    assign s1        = (max_step == '0) ? W'(1) : W'(max_step);
    assign st        = (rem < s1) ? rem : s1;
    assign up_sum    = ctl_r + st;
    assign wu        = dir == UP && up_sum >= p_lat;
    assign wd        = dir == DN && st > ctl_r;
    assign n         = (dir == UP) ? (wu ? up_sum - p_lat : up_sum)
                                   : (wd ? ctl_r + p_lat - st : ctl_r - st);

    pi_mod_dist #(.W(W)) u_dist (
        .cur(ctl_r),
        .tgt(t),
        .p  (p_lat),
        .dir(dist_dir),
        .rem(dist_rem)
    );

    always_comb begin
        state_n = state;
        ctl_n   = ctl_r;
        p_n     = p_lat;
        t_n     = t;
        dir_n   = dir;
        rem_n   = rem;
        hcnt_n  = hcnt;
        err_n   = err_range;
        vld_n   = 1'b0;
        up_n    = 1'b0;
        dn_n    = 1'b0;
        if (!en && state != IDLE) begin
            state_n = IDLE;
        end else begin
            case (state)
                IDLE: if (tgt_valid && tgt_ready) begin
                    p_n     = period;
                    t_n     = tgt_oor ? period - W'(1) : tgt_w;
                    err_n   = err_range | tgt_oor;
                    state_n = CALC;
                end
                CALC: if (ctl_r >= p_lat) begin
                    // illegal current code for this period: clamp, report, re-evaluate
                    ctl_n = p_lat - W'(1);
                    vld_n = 1'b1;
                    err_n = 1'b1;
                end else begin
                    dir_n   = dist_dir;
                    rem_n   = dist_rem;
                    state_n = (dist_rem == '0) ? IDLE : STEP;
                end
                STEP: begin
                    ctl_n   = n;
                    vld_n   = 1'b1;
                    up_n    = wu;
                    dn_n    = wd;
                    rem_n   = rem - st;
                    hcnt_n  = holdoff - Nhold'(1);
                    state_n = (rem_n == '0) ? IDLE : (holdoff == '0) ? STEP : HOLD;
                end
                default: begin
                    hcnt_n  = hcnt - Nhold'(1);
                    state_n = (hcnt == '0) ? STEP : HOLD;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            state     <= IDLE;
            ctl_r     <= '0;
            p_lat     <= '0;
            t         <= '0;
            dir       <= UP;
            rem       <= '0;
            hcnt      <= '0;
            err_range <= 1'b0;
            ctl_valid <= 1'b0;
            wrap_up   <= 1'b0;
            wrap_dn   <= 1'b0;
        end else begin
            state     <= state_n;
            ctl_r     <= ctl_n;
            p_lat     <= p_n;
            t         <= t_n;
            dir       <= dir_n;
            rem       <= rem_n;
            hcnt      <= hcnt_n;
            err_range <= err_n;
            ctl_valid <= vld_n;
            wrap_up   <= up_n;
            wrap_dn   <= dn_n;
        end
    end
endmodule

// File: tb/tb_pi_ctl_sequencer.sv
// tb_pi_ctl_sequencer: directed self-checking bench for pi_ctl_sequencer.
module tb_pi_ctl_sequencer;
    logic       clk = 1'b0;
    logic       rstb, en, tgt_valid;
    logic [9:0] period;
    logic [3:0] max_step, holdoff;
    logic [8:0] tgt_code;
    logic       tgt_ready, ctl_valid, busy, wrap_up, wrap_dn, err_range;
    logic [8:0] ctl;
    int checks = 0, failures = 0, cyc = 0, t_acc = 0, t_p = 0, t_prev = 0;

    pi_ctl_sequencer dut (
        .clk(clk), .rstb(rstb), .en(en), .period(period), .max_step(max_step),
        .holdoff(holdoff), .tgt_valid(tgt_valid), .tgt_code(tgt_code),
        .tgt_ready(tgt_ready), .ctl(ctl), .ctl_valid(ctl_valid), .busy(busy),
        .wrap_up(wrap_up), .wrap_dn(wrap_dn), .err_range(err_range)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rstb = 1'b0;
        @(negedge clk);
        rstb = 1'b1;
    endtask

    task automatic offer(input string tag, input int p, input int s, input int h, input int tg);
        @(negedge clk);
        period = 10'(p); max_step = 4'(s); holdoff = 4'(h); tgt_code = 9'(tg);
        tgt_valid = 1'b1;
        chk({tag, " ready"}, 32'(tgt_ready), 1);
        @(posedge clk);
        #1;
        t_acc = cyc;
        tgt_valid = 1'b0;
    endtask

    task automatic pulse(input string tag, input int ectl, input bit eu, input bit ed);
        bit got = 1'b0;
        for (int k = 0; k < 50; k++) begin
            @(negedge clk);
            if (ctl_valid) begin
                got = 1'b1;
                break;
            end
        end
        chk({tag, " seen"}, 32'(got), 1);
        chk({tag, " ctl"}, 32'(ctl), 32'(ectl));
        chk({tag, " wrap_up"}, 32'(wrap_up), 32'(eu));
        chk({tag, " wrap_dn"}, 32'(wrap_dn), 32'(ed));
        t_prev = t_p;
        t_p = cyc;
    endtask

    task automatic quiet(input string tag, input int ncyc);
        int cnt = 0;
        for (int k = 0; k < ncyc; k++) begin
            @(negedge clk);
            if (ctl_valid) cnt++;
        end
        chk({tag, " no pulses"}, 32'(cnt), 0);
    endtask

    initial begin
        rstb = 1'b0; en = 1'b1; tgt_valid = 1'b0;
        period = 10'd512; max_step = 4'd8; holdoff = 4'd0; tgt_code = 9'd0;
        #1;
        chk("rst ctl", 32'(ctl), 0);
        chk("rst ctl_valid", 32'(ctl_valid), 0);
        chk("rst wrap_up", 32'(wrap_up), 0);
        chk("rst wrap_dn", 32'(wrap_dn), 0);
        chk("rst err", 32'(err_range), 0);
        chk("rst busy", 32'(busy), 0);
        chk("rst ready", 32'(tgt_ready), 1);
        @(negedge clk);
        rstb = 1'b1;

        offer("t1", 512, 8, 0, 20);
        pulse("t1a", 8, 0, 0);
        chk("t1 latency", 32'(t_p - t_acc), 2);
        pulse("t1b", 16, 0, 0);
        chk("t1 spacing b", 32'(t_p - t_prev), 1);
        pulse("t1c", 20, 0, 0);
        chk("t1 spacing c", 32'(t_p - t_prev), 1);
        chk("t1 busy", 32'(busy), 0);
        chk("t1 err", 32'(err_range), 0);

        do_reset();
        offer("t2pre", 512, 15, 0, 500);
        pulse("t2pre", 500, 0, 1);
        offer("t2", 512, 15, 0, 10);
        pulse("t2a", 3, 1, 0);
        pulse("t2b", 10, 0, 0);

        offer("t3pre", 400, 8, 0, 5);
        pulse("t3pre", 5, 0, 0);
        offer("t3", 400, 8, 0, 390);
        pulse("t3a", 397, 0, 1);
        pulse("t3b", 390, 0, 0);
        chk("t3 busy", 32'(busy), 0);

        do_reset();
        offer("t4", 512, 1, 3, 3);
        pulse("t4a", 1, 0, 0);
        chk("t4 ready low", 32'(tgt_ready), 0);
        period = 10'd7;
        tgt_code = 9'd0;
        pulse("t4b", 2, 0, 0);
        chk("t4 spacing b", 32'(t_p - t_prev), 4);
        pulse("t4c", 3, 0, 0);
        chk("t4 spacing c", 32'(t_p - t_prev), 4);
        chk("t4 ready high", 32'(tgt_ready), 1);

        do_reset();
        offer("t5tie", 100, 15, 0, 50);
        pulse("t5a", 15, 0, 0);
        pulse("t5b", 30, 0, 0);
        pulse("t5c", 45, 0, 0);
        pulse("t5d", 50, 0, 0);
        offer("t5back", 100, 15, 0, 0);
        pulse("t5e", 65, 0, 0);
        pulse("t5f", 80, 0, 0);
        pulse("t5g", 95, 0, 0);
        pulse("t5h", 0, 1, 0);
        chk("t5 err clear", 32'(err_range), 0);
        offer("t5oor", 100, 15, 0, 120);
        pulse("t5i", 99, 0, 1);
        chk("t5 err set", 32'(err_range), 1);
        offer("t5clamp", 50, 15, 0, 10);
        pulse("t5j", 49, 0, 0);
        pulse("t5k", 10, 1, 0);
        chk("t5 err sticky", 32'(err_range), 1);

        do_reset();
        chk("p1 err cleared", 32'(err_range), 0);
        offer("p1", 1, 15, 0, 0);
        quiet("p1", 6);
        chk("p1 busy", 32'(busy), 0);
        chk("p1 ctl", 32'(ctl), 0);

        offer("t6", 512, 1, 0, 100);
        pulse("t6a", 1, 0, 0);
        pulse("t6b", 2, 0, 0);
        pulse("t6c", 3, 0, 0);
        pulse("t6d", 4, 0, 0);
        pulse("t6e", 5, 0, 0);
        en = 1'b0;
        quiet("t6 en low", 4);
        chk("t6 ctl hold", 32'(ctl), 5);
        chk("t6 busy", 32'(busy), 0);
        chk("t6 ready en low", 32'(tgt_ready), 0);
        en = 1'b1;
        offer("t6r", 512, 1, 0, 100);
        pulse("t6f", 6, 0, 0);
        pulse("t6g", 7, 0, 0);
        rstb = 1'b0;
        #1;
        chk("t6 rst ctl", 32'(ctl), 0);
        chk("t6 rst ctl_valid", 32'(ctl_valid), 0);
        chk("t6 rst busy", 32'(busy), 0);
        chk("t6 rst wraps", 32'({wrap_up, wrap_dn}), 0);
        chk("t6 rst err", 32'(err_range), 0);
        @(negedge clk);
        rstb = 1'b1;
        quiet("t6 after rst", 4);
        chk("t6 final ctl", 32'(ctl), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
